// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash read sequencer: FSM states, read
// opcodes, header length and the header byte lookup.
// Build option SPI_FAST_READ_EN selects the fast-read opcode with one dummy byte.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR      = 3'd1,
        ST_REQ      = 3'd2,
        ST_DATA     = 3'd3,
        ST_WAIT_FIN = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

`ifdef SPI_FAST_READ_EN
    localparam logic        FAST_EN = 1'b1;
    localparam int unsigned HDR_LEN = 32'd5;
`else
    localparam logic        FAST_EN = 1'b0;
    localparam int unsigned HDR_LEN = 32'd4;
`endif

    localparam logic [7:0]  OP_CODE   = FAST_EN ? OP_FAST_READ : OP_READ;
    localparam logic [23:0] HDR_LEN_W = 24'(HDR_LEN);
    localparam logic [2:0]  HDR_LAST  = 3'(HDR_LEN - 32'd1);

    // Header byte at position idx: opcode, address MSB first, then the dummy byte.
    function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [23:0] addr);
        logic [7:0] b;
        case (idx)
            3'd0:    b = OP_CODE;
            3'd1:    b = addr[23:16];
            3'd2:    b = addr[15:8];
            3'd3:    b = addr[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_rd_skid.sv
// One-entry output register between the SPI master read port and the
// read-data stream; also produces the master-side ready.
module spi_rd_skid
    import spi_flash_pkg::*;
(
    input  logic       rd_clk,
    input  logic       rd_rst_n,
    input  logic       en,
    input  logic       flush,
    input  logic       in_vld,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       cap,
    output logic       out_vld,
    output logic [7:0] out_data,
    output logic       out_last
);

    logic       vld_r;
    logic [7:0] data_r;
    logic       last_r;

    // Accept a new byte only while reading and the slot is free or draining.
    assign in_ready = en && (!vld_r || out_ready);
    assign cap      = in_vld && in_ready;
    assign out_vld  = vld_r;
    assign out_data = data_r;
    assign out_last = last_r;

    // Holding register: load on capture, hold while stalled, drop on flush.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            vld_r  <= 1'b0;
            data_r <= 8'h00;
            last_r <= 1'b0;
        end else begin
            if (flush) begin
                vld_r <= 1'b0;
            end else if (cap) begin
                vld_r <= 1'b1;
            end else if (out_ready) begin
                vld_r <= 1'b0;
            end else begin
                vld_r <= vld_r;
            end
            if (cap && !flush) begin
                data_r <= in_data;
                last_r <= in_last;
            end else begin
                data_r <= data_r;
                last_r <= last_r;
            end
        end
    end

endmodule

// File: rtl/spi_flash_rd_seq.sv
// SPI flash read sequencer: sends the read header through the master write
// port, requests the read, streams the returned bytes out and reports
// completion or a per-byte timeout.
// Build option SPI_FAST_READ_EN (see spi_flash_pkg) selects fast read.
module spi_flash_rd_seq
    import spi_flash_pkg::*;
#(
    parameter logic [2:0]  RD_CMD  = 3'd2,
    parameter int unsigned TIMEOUT = 32'd65535
) (
    input  logic        rd_clk,
    input  logic        rd_rst_n,
    input  logic        cmd_vld,
    output logic        cmd_ready,
    input  logic [23:0] cmd_addr,
    input  logic [23:0] cmd_len,
    output logic        dout_vld,
    input  logic        dout_ready,
    output logic [7:0]  dout_data,
    output logic        dout_last,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        m_request,
    output logic [2:0]  m_req_cmd,
    output logic [23:0] m_req_len,
    output logic [23:0] m_req_wr_len,
    input  logic        m_busy,
    input  logic        m_finish,
    output logic        m_wr_en,
    output logic        m_wr_vld,
    output logic [7:0]  m_wr_data,
    input  logic        m_wr_ready,
    output logic        m_rd_en,
    output logic        m_rd_ready,
    input  logic        m_rd_vld,
    input  logic [7:0]  m_rd_data
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 32'd1);

    state_t      state_r;
    logic [23:0] addr_r;
    logic [23:0] len_r;
    logic [23:0] rem_r;
    logic [2:0]  idx_r;
    logic [15:0] to_cnt_r;
    logic        fin_r;
    logic        err_r;
    logic        run_r;
    logic [2:0]  req_cmd_r;
    logic [23:0] req_len_r;
    logic [23:0] req_wr_len_r;
    logic        rd_cap_s;
    logic        timeout_s;

    // run_r keeps cmd_ready low while reset is applied.
    assign cmd_ready    = run_r && (state_r == ST_IDLE) && !m_busy;
    assign busy         = (state_r != ST_IDLE);
    assign done         = (state_r == ST_DONE);
    assign err          = err_r;
    assign m_request    = (state_r == ST_REQ);
    assign m_req_cmd    = req_cmd_r;
    assign m_req_len    = req_len_r;
    assign m_req_wr_len = req_wr_len_r;
    assign m_wr_en      = (state_r == ST_HDR);
    assign m_wr_vld     = (state_r == ST_HDR);
    assign m_wr_data    = (state_r == ST_HDR) ? hdr_byte(idx_r, addr_r) : 8'h00;
    assign m_rd_en      = (state_r == ST_DATA);

    spi_rd_skid u_skid (
        .rd_clk    (rd_clk),
        .rd_rst_n  (rd_rst_n),
        .en        (state_r == ST_DATA),
        .flush     (timeout_s),
        .in_vld    (m_rd_vld),
        .in_data   (m_rd_data),
        .in_last   (rem_r == 24'd1),
        .out_ready (dout_ready),
        .in_ready  (m_rd_ready),
        .cap       (rd_cap_s),
        .out_vld   (dout_vld),
        .out_data  (dout_data),
        .out_last  (dout_last)
    );

    // Timeout fires when the idle counter is at its last value and this cycle makes no progress.
    always_comb begin
        timeout_s = 1'b0;
        if (to_cnt_r == TO_LAST) begin
            if (state_r == ST_DATA) begin
                timeout_s = !rd_cap_s;
            end else if (state_r == ST_WAIT_FIN) begin
                timeout_s = !(fin_r && !dout_vld);
            end else begin
                timeout_s = 1'b0;
            end
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Sticky record of the master's finish, held from the request until completion.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            fin_r <= 1'b0;
        end else if (state_r == ST_IDLE || state_r == ST_DONE || timeout_s) begin
            fin_r <= 1'b0;
        end else if (m_finish && (state_r == ST_REQ || state_r == ST_DATA || state_r == ST_WAIT_FIN)) begin
            fin_r <= 1'b1;
        end else begin
            fin_r <= fin_r;
        end
    end

    // Main sequencer: command accept, header, request, data, finish wait, timeout.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_r      <= ST_IDLE;
            addr_r       <= 24'd0;
            len_r        <= 24'd0;
            rem_r        <= 24'd0;
            idx_r        <= 3'd0;
            to_cnt_r     <= 16'd0;
            err_r        <= 1'b0;
            run_r        <= 1'b0;
            req_cmd_r    <= 3'd0;
            req_len_r    <= 24'd0;
            req_wr_len_r <= 24'd0;
        end else begin
            run_r <= 1'b1;
            err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    to_cnt_r <= 16'd0;
                    if (cmd_vld && cmd_ready) begin
                        addr_r  <= cmd_addr;
                        len_r   <= cmd_len;
                        rem_r   <= cmd_len;
                        idx_r   <= 3'd0;
                        state_r <= (cmd_len == 24'd0) ? ST_DONE : ST_HDR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HDR: begin
                    to_cnt_r <= 16'd0;
                    if (m_wr_ready && idx_r == HDR_LAST) begin
                        state_r      <= ST_REQ;
                        req_cmd_r    <= RD_CMD;
                        req_len_r    <= len_r;
                        req_wr_len_r <= HDR_LEN_W;
                    end else if (m_wr_ready) begin
                        idx_r <= idx_r + 3'd1;
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                ST_REQ: begin
                    to_cnt_r <= 16'd0;
                    state_r  <= ST_DATA;
                end
                ST_DATA: begin
                    if (rd_cap_s) begin
                        rem_r    <= rem_r - 24'd1;
                        to_cnt_r <= 16'd0;
                        state_r  <= (rem_r == 24'd1) ? ST_WAIT_FIN : ST_DATA;
                    end else if (timeout_s) begin
                        err_r    <= 1'b1;
                        to_cnt_r <= 16'd0;
                        state_r  <= ST_IDLE;
                    end else begin
                        to_cnt_r <= to_cnt_r + 16'd1;
                    end
                end
                ST_WAIT_FIN: begin
                    if (fin_r && !dout_vld) begin
                        to_cnt_r <= 16'd0;
                        state_r  <= ST_DONE;
                    end else if (timeout_s) begin
                        err_r    <= 1'b1;
                        to_cnt_r <= 16'd0;
                        state_r  <= ST_IDLE;
                    end else begin
                        to_cnt_r <= to_cnt_r + 16'd1;
                    end
                end
                ST_DONE: begin
                    to_cnt_r <= 16'd0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    to_cnt_r <= 16'd0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Self-checking bench for spi_flash_rd_seq: reset values, an IDLE handshake
// table, directed multi-cycle sequences and randomized reads checked
// against a transaction-level model of the expected header and data stream.
module tb_spi_flash_rd_seq;

    localparam int TO = 16;

    logic        rd_clk = 1'b0;
    logic        rd_rst_n;
    logic        cmd_vld, cmd_ready;
    logic [23:0] cmd_addr, cmd_len;
    logic        dout_vld, dout_ready, dout_last;
    logic [7:0]  dout_data;
    logic        done, err, busy;
    logic        m_request;
    logic [2:0]  m_req_cmd;
    logic [23:0] m_req_len, m_req_wr_len;
    logic        m_busy, m_finish;
    logic        m_wr_en, m_wr_vld, m_wr_ready;
    logic [7:0]  m_wr_data;
    logic        m_rd_en, m_rd_ready, m_rd_vld;
    logic [7:0]  m_rd_data;

    int checks = 0;
    int failures = 0;

    always #5 rd_clk = ~rd_clk;

    spi_flash_rd_seq #(.RD_CMD(3'd2), .TIMEOUT(TO)) dut (
        .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
        .cmd_vld(cmd_vld), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .dout_vld(dout_vld), .dout_ready(dout_ready), .dout_data(dout_data), .dout_last(dout_last),
        .done(done), .err(err), .busy(busy),
        .m_request(m_request), .m_req_cmd(m_req_cmd), .m_req_len(m_req_len), .m_req_wr_len(m_req_wr_len),
        .m_busy(m_busy), .m_finish(m_finish),
        .m_wr_en(m_wr_en), .m_wr_vld(m_wr_vld), .m_wr_data(m_wr_data), .m_wr_ready(m_wr_ready),
        .m_rd_en(m_rd_en), .m_rd_ready(m_rd_ready), .m_rd_vld(m_rd_vld), .m_rd_data(m_rd_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{cmd_ready, dout_vld, dout_data, dout_last, done, err, busy, m_request,
                 m_req_cmd, m_req_len, m_req_wr_len, m_wr_en, m_wr_vld, m_wr_data,
                 m_rd_en, m_rd_ready};
    endfunction

    // One read transaction with a behavioural master and consumer; results compared
    // against what the command and the master's byte list imply.
    task automatic run_txn(input logic [23:0] addr, input int len, input int nbytes,
                           input int rdy_mode, input bit fin_early, input bit extra,
                           input int rst_at, input string tag);
        logic [7:0] mq[$];
        logic [7:0] eh[$];
        logic [7:0] hdr[$];
        logic [7:0] got[$];
        logic       lastq[$];
        logic [7:0] sdata;
        logic [2:0] rq_cmd;
        logic [23:0] rq_len, rq_wr;
        int mi = 0, req_cnt = 0, done_cnt = 0, err_cnt = 0;
        int last_cap = 0, err_gap = -1, cyc = 0, tail = 0, exp_n;
        bit cmd_pend = 1'b1, m_on = 1'b0, fin_sent = 1'b0, stall = 1'b0;
        bit ok_end = 1'b0, toggle = 1'b1, full;
        rq_cmd = 3'd0; rq_len = 24'd0; rq_wr = 24'd0; sdata = 8'h00;
        for (int i = 0; i < nbytes; i++) mq.push_back(8'($urandom));
`ifdef SPI_FAST_READ_EN
        eh = '{8'h0B, addr[23:16], addr[15:8], addr[7:0], 8'h00};
`else
        eh = '{8'h03, addr[23:16], addr[15:8], addr[7:0]};
`endif
        full  = (nbytes >= len);
        exp_n = full ? len : nbytes;
        while (cyc < 3000) begin
            @(negedge rd_clk);
            cyc++;
            if (stall) begin
                chk({tag, "_stall_vld"}, 32'(dout_vld), 32'd1);
                chk({tag, "_stall_data"}, 32'(dout_data), 32'(sdata));
                stall = 1'b0;
            end
            if (done) done_cnt++;
            if (err) begin
                err_cnt++;
                err_gap = cyc - last_cap;
            end
            if (m_request) begin
                req_cnt++;
                rq_cmd = m_req_cmd; rq_len = m_req_len; rq_wr = m_req_wr_len;
                m_on = 1'b1;
            end
            if (done_cnt + err_cnt > 0) begin
                tail++;
                if (tail > 3) begin
                    ok_end = 1'b1;
                    break;
                end
            end
            if (rst_at > 0 && mi >= rst_at) begin
                rd_rst_n = 1'b0; cmd_vld = 1'b0; m_rd_vld = 1'b0; m_finish = 1'b0;
                #1;
                chk({tag, "_rst_outs_zero"}, 32'(any_out()), 32'd0);
                @(negedge rd_clk);
                rd_rst_n = 1'b1;
                @(negedge rd_clk);
                return;
            end
            cmd_vld    = cmd_pend;
            cmd_addr   = addr;
            cmd_len    = 24'(len);
            m_wr_ready = 1'($urandom_range(0, 1));
            case (rdy_mode)
                0: dout_ready = 1'b1;
                1: begin dout_ready = toggle; toggle = !toggle; end
                default: dout_ready = 1'($urandom_range(0, 1));
            endcase
            m_rd_vld  = m_on && ((mi < nbytes && $urandom_range(0, 3) != 0) || (extra && mi >= nbytes));
            m_rd_data = (mi < nbytes) ? mq[mi] : 8'hEE;
            m_finish  = m_on && full && !fin_sent &&
                        (mi >= nbytes || (fin_early && m_rd_vld && mi == nbytes - 1));
            #1;
            if (m_finish) fin_sent = 1'b1;
            if (cmd_vld && cmd_ready) cmd_pend = 1'b0;
            if (m_wr_vld && m_wr_ready) hdr.push_back(m_wr_data);
            if (m_rd_vld && m_rd_ready) begin
                mi++;
                last_cap = cyc;
            end
            if (dout_vld && dout_ready) begin
                got.push_back(dout_data);
                lastq.push_back(dout_last);
            end
            if (dout_vld && !dout_ready) begin
                stall = 1'b1;
                sdata = dout_data;
            end
        end
        cmd_vld = 1'b0; m_rd_vld = 1'b0; m_finish = 1'b0; dout_ready = 1'b1;
        if (!ok_end) chk({tag, "_end_bound"}, 32'd0, 32'd1);
        chk({tag, "_hdr_len"}, 32'(hdr.size()), 32'(eh.size()));
        for (int i = 0; i < eh.size() && i < hdr.size(); i++)
            chk({tag, "_hdr_byte"}, 32'(hdr[i]), 32'(eh[i]));
        chk({tag, "_req_cnt"}, 32'(req_cnt), 32'd1);
        chk({tag, "_req_cmd"}, 32'(rq_cmd), 32'd2);
        chk({tag, "_req_len"}, 32'(rq_len), 32'(len));
        chk({tag, "_req_wr_len"}, 32'(rq_wr), 32'(eh.size()));
        chk({tag, "_dout_cnt"}, 32'(got.size()), 32'(exp_n));
        for (int i = 0; i < got.size() && i < exp_n; i++) begin
            chk({tag, "_dout_data"}, 32'(got[i]), 32'(mq[i]));
            chk({tag, "_dout_last"}, 32'(lastq[i]), 32'(i == len - 1));
        end
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(full));
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(!full));
        // err is raised by the TO-th edge after the capture edge and is first seen
        // at the negedge that follows it.
        if (!full) chk({tag, "_err_gap"}, 32'(err_gap), 32'(TO + 1));
        chk({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic busy_in;
        logic vld_in;
        logic exp_ready;
        logic exp_busy;
        logic exp_done;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{busy_in: 1'b1, vld_in: 1'b1, exp_ready: 1'b0, exp_busy: 1'b0, exp_done: 1'b0};
        vecs[1] = '{busy_in: 1'b0, vld_in: 1'b0, exp_ready: 1'b1, exp_busy: 1'b0, exp_done: 1'b0};
        vecs[2] = '{busy_in: 1'b0, vld_in: 1'b1, exp_ready: 1'b1, exp_busy: 1'b1, exp_done: 1'b1};
        vecs[3] = '{busy_in: 1'b1, vld_in: 1'b0, exp_ready: 1'b0, exp_busy: 1'b0, exp_done: 1'b0};

        rd_rst_n = 1'b0; cmd_vld = 1'b0; cmd_addr = 24'd0; cmd_len = 24'd0;
        dout_ready = 1'b0; m_busy = 1'b0; m_finish = 1'b0; m_wr_ready = 1'b0;
        m_rd_vld = 1'b0; m_rd_data = 8'h00;
        repeat (3) @(negedge rd_clk);
        chk("reset_outs_zero", 32'(any_out()), 32'd0);
        rd_rst_n = 1'b1;
        @(negedge rd_clk);

        // IDLE handshake table: cmd_ready vs m_busy, zero-length command.
        for (int i = 0; i < 4; i++) begin
            @(negedge rd_clk);
            m_busy = vecs[i].busy_in; cmd_vld = vecs[i].vld_in; cmd_len = 24'd0; cmd_addr = 24'h0;
            #1;
            chk("tbl_cmd_ready", 32'(cmd_ready), 32'(vecs[i].exp_ready));
            @(negedge rd_clk);
            cmd_vld = 1'b0;
            chk("tbl_busy", 32'(busy), 32'(vecs[i].exp_busy));
            chk("tbl_done", 32'(done), 32'(vecs[i].exp_done));
            chk("tbl_no_master", 32'({m_request, m_wr_vld}), 32'd0);
            @(negedge rd_clk);
            chk("tbl_done_pulse", 32'(done), 32'd0);
            chk("tbl_no_master2", 32'({m_request, m_wr_vld}), 32'd0);
            m_busy = 1'b0;
        end

        run_txn(24'h123456, 4, 4, 0, 1'b0, 1'b0, 0, "basic");
        run_txn(24'hABCDEF, 3, 3, 1, 1'b0, 1'b1, 0, "stall");
        run_txn(24'h000010, 2, 2, 0, 1'b1, 1'b0, 0, "fin_early");
        run_txn(24'h0F00F0, 8, 2, 0, 1'b0, 1'b0, 0, "timeout");
        run_txn(24'h55AA55, 6, 6, 0, 1'b0, 1'b0, 3, "rst_mid");
        run_txn(24'h010203, 2, 2, 0, 1'b0, 1'b0, 0, "after_rst");

        for (int k = 0; k < 8; k++) begin
            int ln;
            ln = $urandom_range(1, 6);
            run_txn(24'($urandom), ln, ln, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_flash_rd_seq.md
SPI_FLASH_RD_SEQ -- requirements
Module: spi_flash_rd_seq

Interface
REQ-001 Parameter RD_CMD, default 3'd2: req_cmd code the SPI master decodes as "write header, then read".
REQ-002 Parameter TIMEOUT, default 65535: idle-cycle limit per byte in DATA/WAIT_FIN; 16-bit counter.
REQ-003 rd_clk  in  1  sole clock; the integrating top ties the master's wr_clk and rd_clk to it.
REQ-004 rd_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cmd_vld  in  1 / cmd_ready  out  1  command handshake; transfer when both are high.
REQ-006 cmd_addr  in  24  flash byte address / cmd_len  in  24  read byte count.
REQ-007 dout_vld  out  1 / dout_ready  in  1 / dout_data  out  8 / dout_last  out  1  read-data stream.
REQ-008 done  out  1  1-cycle pulse at normal completion / err  out  1  1-cycle pulse at timeout / busy  out  1  state != IDLE.
REQ-009 m_request  out  1, m_req_cmd  out  3, m_req_len  out  24, m_req_wr_len  out  24  master control; m_busy  in  1, m_finish  in  1.
REQ-010 m_wr_en  out  1, m_wr_vld  out  1, m_wr_data  out  8, m_wr_ready  in  1  master write port.
REQ-011 m_rd_en  out  1, m_rd_ready  out  1, m_rd_vld  in  1, m_rd_data  in  8  master read port.

Function
REQ-012 FSM states: IDLE, HDR, REQ, DATA, WAIT_FIN, DONE; one-hot or binary is free.
REQ-013 IDLE: cmd_ready=1 only when m_busy=0; on accept, latch addr/len, clear byte index, go HDR; cmd_len=0 goes directly to DONE with no master request.
REQ-014 HDR: m_wr_en=1, m_wr_vld=1; bytes in order 0x03, addr[23:16], addr[15:8], addr[7:0]; index advances only on m_wr_vld&&m_wr_ready; after last header byte, go REQ.
REQ-015 REQ: m_request high for exactly one cycle, m_req_cmd=RD_CMD, m_req_wr_len=header length (4), m_req_len=latched cmd_len; next state DATA.
REQ-016 m_req_* outputs hold their values from REQ until the next REQ.
REQ-017 DATA: m_rd_en=1, m_rd_ready = !dout_vld || dout_ready; byte captured into the dout register on m_rd_vld&&m_rd_ready, dout_vld set the following cycle.
REQ-018 dout_vld clears on dout_ready with no new capture; dout_data/dout_last stable while dout_vld&&!dout_ready.
REQ-019 Remaining-byte counter loaded with cmd_len and decremented per capture; dout_last=1 on the byte captured when the counter is 1; after that capture go WAIT_FIN.
REQ-020 m_finish is latched sticky from REQ onward, including when it arrives during DATA; WAIT_FIN exits to DONE when the latch is set and dout_vld=0.
REQ-021 DONE: done=1 for one cycle, clear the finish latch, return to IDLE.
REQ-022 Timeout counter clears on every state change and every capture and increments otherwise in DATA/WAIT_FIN; on reaching TIMEOUT, err=1 for one cycle, dout_vld=0, return to IDLE, no done.
REQ-023 Extra m_rd_vld after the final byte is not accepted: m_rd_ready=0 outside DATA.
REQ-024 cmd_vld during a non-IDLE state is ignored (cmd_ready=0).

Reset
REQ-025 Asynchronous reset forces IDLE; all outputs 0; dout_data=8'h00; m_req_* =0; counters and latches cleared; mid-transfer data is discarded.

Configuration
REQ-026 Macro SPI_FAST_READ_EN, when defined: opcode 0x0B, one dummy byte 0x00 appended after addr[7:0], m_req_wr_len=5; when undefined: opcode 0x03, no dummy byte, m_req_wr_len=4.

Structure
REQ-027 Shared package spi_flash_pkg holds the state enum, opcode constants (OP_READ=8'h03, OP_FAST_READ=8'h0B) and the header-length constant.
REQ-028 One sub-module, spi_rd_skid, implements the 1-entry dout register and the m_rd_ready logic; the rest is flat.

Verification
REQ-029 addr=0x123456, len=4, dout_ready=1: write bytes 03,12,34,56; one m_request with wr_len=4 and len=4; 4 dout beats, last on the 4th; done once.
REQ-030 len=3 with dout_ready toggling 1/0 each cycle: no byte is lost or duplicated; dout_data is stable while stalled.
REQ-031 With SPI_FAST_READ_EN defined, addr=0x000010: header is 0B,00,00,10,00 and m_req_wr_len=5.
REQ-032 len=0: done 1 cycle after accept; no m_request and no m_wr_vld.
REQ-033 TIMEOUT=16, master stops after 2 of 8 bytes: err pulses 16 cycles after the last capture, no done, back in IDLE and cmd_ready=1.
REQ-034 rd_rst_n asserted during DATA: all outputs 0 immediately; a next command with len=2 completes normally.
